// File: rtl/mblock_pkg.sv
// Shared definitions for the memory-block arbiter: selector codes,
// FSM state encoding and the default ready timeout.
package mblock_pkg;

    typedef enum logic [1:0] {
        SEL_RAM   = 2'd0,
        SEL_BROM  = 2'd1,
        SEL_IO    = 2'd2,
        SEL_CONST = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    localparam int TIMEOUT_DEFAULT = 15;

    // Index width that stays at least one bit for single-entry cases.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mblock_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searched
// upward from (last_grant+1) mod NUM_PORTS, wrapping around.
module rr_picker #(
    parameter int NUM_PORTS = 4,
    parameter int GID_W     = 2
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [GID_W-1:0]     last_grant,
    output logic [GID_W-1:0]     winner,
    output logic                 valid
);

    logic [GID_W-1:0] w_cand;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_cand = '0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            w_cand = GID_W'((int'(last_grant) + i) % NUM_PORTS);
            if (!valid && req[w_cand]) begin
                winner = w_cand;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mblock_arbiter.sv
// Multi-port arbiter in front of a set of memory blocks: one access at a
// time, round-robin fairness, ready timeout with error response.
module mblock_arbiter
    import mblock_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 32,
    parameter int SEL_W     = 2,
    parameter int TIMEOUT   = TIMEOUT_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS-1:0]          req,
    input  logic [NUM_PORTS-1:0]          is_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]   address,
    input  logic [NUM_PORTS*DATA_W-1:0]   wdata,
    input  logic                          boot_brom,
    output logic [NUM_PORTS-1:0]          ack,
    output logic                          err,
    output logic [DATA_W-1:0]             rdata,
    output logic [clog2_min1(NUM_PORTS)-1:0] grant_id,
    output logic                          busy,
    output logic [ADDR_W-SEL_W-1:0]       mblock_address,
    output logic [SEL_W-1:0]              mblock_selector,
    output logic                          mblock_write,
    output logic [DATA_W-1:0]             mblock_wdata,
    input  logic                          mblock_ready,
    input  logic [DATA_W-1:0]             mblock_rdata
);

    localparam int GID_W  = clog2_min1(NUM_PORTS);
    localparam int WAIT_W = clog2_min1(TIMEOUT + 1);
    localparam int MADR_W = ADDR_W - SEL_W;

    state_e                 r_state;
    state_e                 w_next;

    logic [GID_W-1:0]       r_last_grant;
    logic                   r_granted_once;
    logic [GID_W-1:0]       r_grant_id;
    logic [GID_W-1:0]       w_pick_base;
    logic [GID_W-1:0]       w_winner;
    logic                   w_valid;

    logic [ADDR_W-1:0]      w_win_addr;
    logic [DATA_W-1:0]      w_win_wdata;
    logic                   w_win_write;
    logic                   w_force_brom;

    logic                   r_is_write;
    logic [MADR_W-1:0]      r_maddr;
    logic [SEL_W-1:0]       r_sel;
    logic [DATA_W-1:0]      r_wdata;

    logic [WAIT_W-1:0]      r_wait;
    logic                   w_timeout;

    logic [NUM_PORTS-1:0]   r_ack;
    logic                   r_err;
    logic [DATA_W-1:0]      r_rdata;

    // Until the first grant after reset, search as if port NUM_PORTS-1 had
    // just been served so the sweep begins at port 0.
    assign w_pick_base = r_granted_once ? r_last_grant : GID_W'(NUM_PORTS - 1);

    rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .GID_W     (GID_W)
    ) u_picker (
        .req        (req),
        .last_grant (w_pick_base),
        .winner     (w_winner),
        .valid      (w_valid)
    );

    assign w_win_addr   = address[int'(w_winner)*ADDR_W +: ADDR_W];
    assign w_win_wdata  = wdata[int'(w_winner)*DATA_W +: DATA_W];
    assign w_win_write  = is_write[w_winner];
    assign w_force_brom = boot_brom && (w_winner == '0) && !w_win_write;

    // The counter reaches TIMEOUT on the edge that leaves ACCESS.
    assign w_timeout = (r_wait == WAIT_W'(TIMEOUT - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_valid) w_next = ST_ACCESS;
            ST_ACCESS: if (mblock_ready || w_timeout) w_next = ST_RESP;
            ST_RESP:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_grant   <= '0;
            r_granted_once <= 1'b0;
            r_grant_id     <= '0;
            r_is_write     <= 1'b0;
            r_maddr        <= '0;
            r_sel          <= '0;
            r_wdata        <= '0;
            r_wait         <= '0;
            r_ack          <= '0;
            r_err          <= 1'b0;
            r_rdata        <= '0;
        end else begin
            r_ack   <= '0;
            r_err   <= 1'b0;
            r_rdata <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_grant_id <= w_winner;
                        r_is_write <= w_win_write;
                        r_maddr    <= w_win_addr[MADR_W-1:0];
                        r_sel      <= w_force_brom ? SEL_W'(SEL_BROM)
                                                   : w_win_addr[ADDR_W-1 -: SEL_W];
                        r_wdata    <= w_win_wdata;
                        r_wait     <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (mblock_ready) begin
                        r_ack   <= NUM_PORTS'(1) << r_grant_id;
                        r_rdata <= r_is_write ? '0 : mblock_rdata;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                        if (w_timeout) begin
                            r_ack <= NUM_PORTS'(1) << r_grant_id;
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_RESP: begin
                    r_last_grant   <= r_grant_id;
                    r_granted_once <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign rdata    = r_rdata;
    assign grant_id = r_grant_id;
    assign busy     = (r_state != ST_IDLE);

    // Memory-side signals are visible only while an access is in flight.
    assign mblock_address  = (r_state == ST_ACCESS) ? r_maddr : '0;
    assign mblock_selector = (r_state == ST_ACCESS) ? r_sel   : '0;
    assign mblock_write    = (r_state == ST_ACCESS) && r_is_write;
    assign mblock_wdata    = (r_state == ST_ACCESS) ? r_wdata : '0;

endmodule

// File: tb/tb_mblock_arbiter.sv
// Directed bench for mblock_arbiter: reset, single read, contention,
// waited write, timeout, boot override and reset abort.
module tb_mblock_arbiter;

    localparam int NP = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int SW = 2;
    localparam int TO = 15;

    logic              clk;
    logic              reset;
    logic [NP-1:0]     req;
    logic [NP-1:0]     is_write;
    logic [NP*AW-1:0]  address;
    logic [NP*DW-1:0]  wdata;
    logic              boot_brom;
    logic [NP-1:0]     ack;
    logic              err;
    logic [DW-1:0]     rdata;
    logic [1:0]        grant_id;
    logic              busy;
    logic [AW-SW-1:0]  mblock_address;
    logic [SW-1:0]     mblock_selector;
    logic              mblock_write;
    logic [DW-1:0]     mblock_wdata;
    logic              mblock_ready;
    logic [DW-1:0]     mblock_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mblock_arbiter #(
        .NUM_PORTS (NP),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .SEL_W     (SW),
        .TIMEOUT   (TO)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req             (req),
        .is_write        (is_write),
        .address         (address),
        .wdata           (wdata),
        .boot_brom       (boot_brom),
        .ack             (ack),
        .err             (err),
        .rdata           (rdata),
        .grant_id        (grant_id),
        .busy            (busy),
        .mblock_address  (mblock_address),
        .mblock_selector (mblock_selector),
        .mblock_write    (mblock_write),
        .mblock_wdata    (mblock_wdata),
        .mblock_ready    (mblock_ready),
        .mblock_rdata    (mblock_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        req          = '0;
        is_write     = '0;
        address      = '0;
        wdata        = '0;
        boot_brom    = 1'b0;
        mblock_ready = 1'b0;
        mblock_rdata = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        req          = '0;
        is_write     = '0;
        address      = '0;
        wdata        = '0;
        boot_brom    = 1'b0;
        mblock_ready = 1'b0;
        mblock_rdata = '0;
        tick();
        tick();
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if ({mblock_address, mblock_selector, mblock_write, mblock_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_mblock: got addr %h sel %0d wr %b wdata %h expected all 0",
                               mblock_address, mblock_selector, mblock_write, mblock_wdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_read();
        req = 4'b0100;
        is_write = '0;
        address[2*AW +: AW] = 16'h4010;
        tick();                                  // ACCESS
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rd_busy: got %b expected 1", busy); end
        n_checks++; if (mblock_selector !== 2'd1) begin n_fail++; $display("FAIL rd_selector: got %0d expected 1", mblock_selector); end
        n_checks++; if (mblock_address !== 14'h0010) begin n_fail++; $display("FAIL rd_maddr: got %h expected 0010", mblock_address); end
        n_checks++; if (mblock_write !== 1'b0) begin n_fail++; $display("FAIL rd_write: got %b expected 0", mblock_write); end
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rd_early_ack: got %b expected 0000", ack); end
        req = '0;
        mblock_ready = 1'b1;
        mblock_rdata = 32'hDEADBEEF;
        tick();                                  // RESP, third cycle
        mblock_ready = 1'b0;
        mblock_rdata = 32'h0;
        n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL rd_ack: got %b expected 0100", ack); end
        n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_rdata: got %h expected deadbeef", rdata); end
        n_checks++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL rd_grant_id: got %0d expected 2", grant_id); end
        n_checks++; if (mblock_selector !== 2'd0) begin n_fail++; $display("FAIL rd_sel_resp: got %0d expected 0", mblock_selector); end
        tick();                                  // IDLE
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL rd_ack_one_cycle: got %b expected 0000", ack); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_idle: got %b expected 0", busy); end
    endtask

    task automatic test_contention();
        int exp_order[5];
        logic [3:0] exp_ack;
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        req = 4'b1111;
        mblock_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            exp_ack = 4'b0001 << exp_order[g];
            tick();                              // ACCESS
            n_checks++; if (grant_id !== 2'(exp_order[g])) begin
                n_fail++; $display("FAIL cont_grant_%0d: got %0d expected %0d", g, grant_id, exp_order[g]);
            end
            tick();                              // RESP
            n_checks++; if (ack !== exp_ack) begin
                n_fail++; $display("FAIL cont_ack_%0d: got %b expected %b", g, ack, exp_ack);
            end
            tick();                              // IDLE
            n_checks++; if (ack !== 4'b0000) begin
                n_fail++; $display("FAIL cont_ack_width_%0d: got %b expected 0000", g, ack);
            end
        end
        req = '0;
        mblock_ready = 1'b0;
        tick();
    endtask

    task automatic test_write_waits();
        int wr_cycles;
        int unstable;
        wr_cycles = 0;
        unstable  = 0;
        req = 4'b0010;
        is_write = 4'b0010;
        address[1*AW +: AW] = 16'h8005;
        wdata[1*DW +: DW]   = 32'h12345678;
        mblock_rdata = 32'hAAAA5555;
        tick();                                  // first ACCESS cycle
        req = '0;
        is_write = '0;
        address[1*AW +: AW] = 16'hFFFF;
        wdata[1*DW +: DW]   = 32'h0;
        for (int i = 0; i < 5; i++) begin
            if (mblock_write === 1'b1) wr_cycles++;
            if (mblock_selector !== 2'd2 || mblock_address !== 14'h0005 ||
                mblock_wdata !== 32'h12345678 || ack !== 4'b0000)
                unstable++;
            if (i == 4) mblock_ready = 1'b1;
            tick();
        end
        mblock_ready = 1'b0;
        n_checks++; if (wr_cycles !== 5) begin n_fail++; $display("FAIL wr_write_cycles: got %0d expected 5", wr_cycles); end
        n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL wr_stable: got %0d unstable cycles expected 0", unstable); end
        n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL wr_ack: got %b expected 0010", ack); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata: got %h expected 0", rdata); end
        n_checks++; if (mblock_write !== 1'b0) begin n_fail++; $display("FAIL wr_write_resp: got %b expected 0", mblock_write); end
        tick();
        mblock_rdata = '0;
    endtask

    task automatic test_timeout();
        int n;
        int early_err;
        early_err = 0;
        req = 4'b1000;
        address[3*AW +: AW] = 16'hC123;
        mblock_rdata = 32'h55555555;
        n = 1;                                   // IDLE sampling cycle
        tick();
        n = 2;
        req = '0;
        while (ack === 4'b0000 && n < 40) begin
            if (err !== 1'b0) early_err++;
            tick();
            n++;
        end
        n_checks++; if (n !== TO + 2) begin n_fail++; $display("FAIL to_latency: got %0d cycles expected %0d", n, TO + 2); end
        n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL to_ack: got %b expected 1000", ack); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL to_err: got %b expected 1", err); end
        n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL to_rdata: got %h expected 0", rdata); end
        n_checks++; if (early_err !== 0) begin n_fail++; $display("FAIL to_early_err: got %0d expected 0", early_err); end
        tick();
        n_checks++; if ({err, ack} !== 5'b0) begin n_fail++; $display("FAIL to_err_one_cycle: got err %b ack %b expected 0", err, ack); end
        req = 4'b0001;
        address[0 +: AW] = 16'h0004;
        mblock_rdata = 32'h0BADF00D;
        mblock_ready = 1'b1;
        tick();
        n_checks++; if (mblock_address !== 14'h0004) begin n_fail++; $display("FAIL to_next_maddr: got %h expected 0004", mblock_address); end
        tick();
        n_checks++; if (ack !== 4'b0001 || err !== 1'b0) begin
            n_fail++; $display("FAIL to_next_ack: got ack %b err %b expected 0001 0", ack, err);
        end
        n_checks++; if (rdata !== 32'h0BADF00D) begin n_fail++; $display("FAIL to_next_rdata: got %h expected 0badf00d", rdata); end
        req = '0;
        mblock_ready = 1'b0;
        mblock_rdata = '0;
        tick();
    endtask

    task automatic test_boot_reset_abort();
        boot_brom = 1'b1;
        req = 4'b0001;
        is_write = '0;
        address[0 +: AW] = 16'h0000;
        tick();                                  // ACCESS
        n_checks++; if (mblock_selector !== 2'd1) begin n_fail++; $display("FAIL boot_selector: got %0d expected 1", mblock_selector); end
        n_checks++; if (mblock_address !== 14'h0) begin n_fail++; $display("FAIL boot_maddr: got %h expected 0", mblock_address); end
        tick();                                  // still waiting in ACCESS
        reset = 1'b1;
        req = '0;
        tick();
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL abort_ack: got %b expected 0000", ack); end
        n_checks++; if ({busy, err, rdata, grant_id} !== '0) begin
            n_fail++; $display("FAIL abort_status: got busy %b err %b rdata %h gid %0d expected 0", busy, err, rdata, grant_id);
        end
        n_checks++; if ({mblock_address, mblock_selector, mblock_write, mblock_wdata} !== '0) begin
            n_fail++; $display("FAIL abort_mblock: got addr %h sel %0d wr %b wdata %h expected 0",
                               mblock_address, mblock_selector, mblock_write, mblock_wdata);
        end
        reset = 1'b0;
        boot_brom = 1'b0;
        tick();
        n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL abort_no_late_ack: got %b expected 0000", ack); end
        req = 4'b1001;
        address[0 +: AW]    = 16'hC000;
        address[3*AW +: AW] = 16'h4000;
        tick();
        n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL abort_next_grant: got %0d expected 0", grant_id); end
        n_checks++; if (mblock_selector !== 2'd3) begin n_fail++; $display("FAIL abort_next_sel: got %0d expected 3", mblock_selector); end
        mblock_ready = 1'b1;
        tick();
        n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL abort_next_ack: got %b expected 0001", ack); end
        req = '0;
        mblock_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_write_waits();
        test_timeout();
        test_boot_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mblock_arbiter.md
MBLOCK_ARBITER -- requirements
Module: mblock_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_PORTS, default 4, number of requesters
- ADDR_W, default 16, requester address width
- DATA_W, default 32, data width
- SEL_W, default 2, memory-block selector width
- TIMEOUT, default 15, maximum wait cycles for mblock_ready
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req  in  NUM_PORTS  per-port access request
- is_write  in  NUM_PORTS  per-port write flag
- address  in  NUM_PORTS*ADDR_W  flattened per-port addresses; port i at [i*ADDR_W +: ADDR_W]
- wdata  in  NUM_PORTS*DATA_W  flattened per-port write data
- boot_brom  in  1  force port-0 reads to BROM
- ack  out  NUM_PORTS  one-cycle completion pulse
- err  out  1  one-cycle timeout pulse, coincident with ack
- rdata  out  DATA_W  read data, valid while ack is high
- grant_id  out  clog2(NUM_PORTS)  current or last winner
- busy  out  1  arbiter not in IDLE
- mblock_address  out  ADDR_W-SEL_W  in-block address
- mblock_selector  out  SEL_W  target block
- mblock_write  out  1  write strobe
- mblock_wdata  out  DATA_W  write data
- mblock_ready  in  1  target completed the access
- mblock_rdata  in  DATA_W  target read data

Function
REQ-004 The FSM SHALL have three states, IDLE, ACCESS and RESP, with these transitions:
- IDLE to ACCESS when any req bit is set.
- ACCESS to RESP on mblock_ready or on timeout.
- RESP to IDLE unconditionally.
REQ-005 In IDLE, the winner SHALL be the first set req bit searched round-robin, starting at (last_grant+1) mod NUM_PORTS.
REQ-006 On the IDLE-to-ACCESS edge, the block SHALL latch the winner's address, is_write and wdata; later changes to that port's inputs, including req deassertion, SHALL be ignored until ack.
REQ-007 The selector SHALL be the latched address[ADDR_W-1 -: SEL_W], and mblock_address SHALL be the remaining low bits.
REQ-008 The selector SHALL be forced to BROM when boot_brom=1, the winner is port 0 and is_write=0.
REQ-009 mblock_* outputs SHALL be driven only in ACCESS, held stable throughout ACCESS, and zero otherwise.
REQ-010 mblock_write SHALL be high for every ACCESS cycle of a write.
REQ-011 mblock_ready SHALL be ignored outside ACCESS.
REQ-012 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without ready.
REQ-013 When the wait counter reaches TIMEOUT, the block SHALL go to RESP with err=1 and rdata=0.
REQ-014 In RESP, ack[grant_id] SHALL pulse for one cycle, and rdata SHALL hold the data captured on the ready cycle (0 for writes).
REQ-015 last_grant SHALL update in RESP; wrap from NUM_PORTS-1 to 0 is required.
REQ-016 Minimum latency SHALL be 3 cycles from req sampled in IDLE to ack, with ready in the first ACCESS cycle.
REQ-017 Throughput SHALL be one access per 3+waits cycles.
REQ-018 A requester holding req after ack SHALL be re-arbitrated in the next IDLE with lowest round-robin priority.
REQ-019 With all ports requesting continuously, each port SHALL be served exactly once per NUM_PORTS grants.

Reset
REQ-020 On reset the block SHALL enter IDLE and set all of the following to 0: last_grant, wait counter, ack, err, rdata, grant_id, busy and every mblock_* output.
REQ-021 Reset mid-ACCESS SHALL abort the access without ack, and the first post-reset grant SHALL search from port 0.

Structure
REQ-022 The selector encoding (RAM=0, BROM=1, IO=2, CONST=3), the FSM state encoding and the default TIMEOUT SHALL live in shared package mblock_pkg.
REQ-023 The round-robin priority picker SHALL be one combinational sub-module, rr_picker (inputs req and last_grant; outputs winner and valid).

Verification
REQ-024 The bench SHALL cover these directed scenarios (stimulus -> required response):
- Single read: port 2, address 0x4010, ready on first ACCESS cycle, mblock_rdata 0xDEADBEEF -> selector=1, mblock_address=0x0010, ack=0100 at cycle 3, rdata=0xDEADBEEF.
- Contention: all 4 ports request continuously after reset -> grants in order 0,1,2,3,0, each ack exactly one cycle.
- Write with waits: port 1 write to address 0x8005, data 0x12345678, ready after 4 cycles -> mblock_write high for 5 cycles, outputs stable throughout, ack=0010, rdata=0.
- Timeout: mblock_ready never asserted -> err and ack pulse together after TIMEOUT+2 cycles, rdata=0, next request is served normally.
- Boot override and reset abort: boot_brom=1, port 0 read at 0x0000 -> selector=1; reset asserted mid-ACCESS -> no ack, all outputs 0, next grant goes to port 0.
